// File: rtl/spram_ctrl.sv
// Initiator-side controller for a 256x8 single-port RAM macro with a power-up quiet period.
// Build option: define SPRAM_CLEAR_EN to zero-fill the whole array after the quiet period.
module spram_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int INIT_CYCLES = 120
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              ram_enb,
  output logic              ram_web,
  output logic              ram_oeb,
  output logic [ADDR_W-1:0] ram_adr,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int CNT_W = $clog2(INIT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_INIT, S_CLEAR, S_IDLE, S_ACCESS, S_CAPTURE, S_RSP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wr_p0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_INIT;
      cnt       <= '0;
      wr_p0     <= 1'b0;
      ram_enb   <= 1'b1;
      ram_web   <= 1'b1;
      ram_oeb   <= 1'b1;
      ram_adr   <= '0;
      ram_d     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          ram_enb <= 1'b1;
          if (cnt == CNT_W'(INIT_CYCLES - 1)) begin
            cnt <= '0;
`ifdef SPRAM_CLEAR_EN
            state   <= S_CLEAR;
            ram_enb <= 1'b0;
            ram_web <= 1'b0;
            ram_d   <= '0;
            ram_adr <= '0;
`else
            state     <= S_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef SPRAM_CLEAR_EN
        // Enable stays low for the whole sweep: one zero write per clock.
        S_CLEAR: begin
          if (ram_adr == '1) begin
            ram_enb   <= 1'b1;
            ram_web   <= 1'b1;
            state     <= S_IDLE;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            ram_adr <= ram_adr + ADDR_W'(1);
          end
        end
`endif
        S_IDLE: begin
          if (req_valid && req_ready) begin
            ram_enb   <= 1'b0;
            ram_web   <= ~req_we;
            ram_adr   <= req_addr;
            wr_p0     <= req_we;
            req_ready <= 1'b0;
            if (req_we) ram_d <= req_wdata;
            state <= S_ACCESS;
          end
        end
        // Macro latches the access on this edge; drop enable so it is a single-clock strobe.
        S_ACCESS: begin
          ram_enb <= 1'b1;
          ram_web <= 1'b1;
          if (wr_p0) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            ram_oeb <= 1'b0;
            state   <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          rsp_rdata <= ram_q;
          rsp_valid <= 1'b1;
          ram_oeb   <= 1'b1;
          state     <= S_RSP;
        end
        S_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_ctrl.sv
// Directed bench for spram_ctrl with a behavioural 256x8 RAM macro attached to its pins.
module tb_spram_ctrl;

  localparam int INIT_CYCLES = 120;
`ifdef SPRAM_CLEAR_EN
  localparam int INIT_EXP = INIT_CYCLES + 256;
  localparam int CLR_WR   = 256;
`else
  localparam int INIT_EXP = INIT_CYCLES;
  localparam int CLR_WR   = 0;
`endif

  logic       CLK;
  logic       RST;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       init_done;
  logic       ram_enb, ram_web, ram_oeb;
  logic [7:0] ram_adr, ram_d, ram_q;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_strobes  = 0;
  int enb_strobes = 0;

  spram_ctrl #(.ADDR_W(8), .DATA_W(8), .INIT_CYCLES(INIT_CYCLES)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .ram_enb(ram_enb), .ram_web(ram_web), .ram_oeb(ram_oeb),
    .ram_adr(ram_adr), .ram_d(ram_d), .ram_q(ram_q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM macro: synchronous access on CLK rise, Q only driven while OEB is low.
  logic [7:0] mem [256];
  logic [7:0] q_reg = 8'h00;
  always @(posedge CLK) begin
    if (!ram_enb) begin
      if (!ram_web) mem[ram_adr] <= ram_d;
      else          q_reg        <= mem[ram_adr];
    end
  end
  assign ram_q = ram_oeb ? 8'hzz : q_reg;

  always @(posedge CLK) begin
    if (!RST && !ram_enb) enb_strobes <= enb_strobes + 1;
    if (!RST && !ram_enb && !ram_web) wr_strobes <= wr_strobes + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic init_wait(input string tag);
    int bad_rdy = 0;
    int bad_enb = 0;
    int w0 = wr_strobes;
    for (int k = 1; k < INIT_EXP; k++) begin
      @(posedge CLK); #1;
      if (req_ready !== 1'b0 || init_done !== 1'b0) bad_rdy++;
      if (k < INIT_CYCLES && ram_enb !== 1'b1) bad_enb++;
    end
    check({tag, "_quiet_ready"}, bad_rdy, 0);
    check({tag, "_quiet_enb"}, bad_enb, 0);
    @(posedge CLK); #1;
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_init_done"}, init_done, 1'b1);
    check({tag, "_enb_idle"}, ram_enb, 1'b1);
    check({tag, "_clear_writes"}, wr_strobes - w0, CLR_WR);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    int e0 = enb_strobes;
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("wr_enb_low", ram_enb, 1'b0);
    check("wr_web_low", ram_web, 1'b0);
    check("wr_adr", ram_adr, addr);
    check("wr_d", ram_d, data);
    check("wr_ready_low", req_ready, 1'b0);
    @(posedge CLK); #1;
    check("wr_enb_high", ram_enb, 1'b1);
    check("wr_ready_back", req_ready, 1'b1);
    check("wr_one_strobe", enb_strobes - e0, 1);
  endtask

  task automatic do_read(input logic [7:0] addr, input logic [7:0] exp, input int stall);
    int e0 = enb_strobes;
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wdata = 8'hEE;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("rd_enb_low", ram_enb, 1'b0);
    check("rd_web_high", ram_web, 1'b1);
    check("rd_adr", ram_adr, addr);
    @(posedge CLK); #1;
    check("rd_e1_enb", ram_enb, 1'b1);
    check("rd_e1_oeb", ram_oeb, 1'b0);
    check("rd_e1_no_rsp", rsp_valid, 1'b0);
    if (stall > 0) rsp_ready = 1'b0;
    @(posedge CLK); #1;
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rdata", rsp_rdata, exp);
    check("rd_oeb_off", ram_oeb, 1'b1);
    for (int s = 0; s < stall; s++) begin
      @(posedge CLK); #1;
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_rdata", rsp_rdata, exp);
      check("stall_ready", req_ready, 1'b0);
      check("stall_enb", ram_enb, 1'b1);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    check("rd_rsp_done", rsp_valid, 1'b0);
    check("rd_ready_back", req_ready, 1'b1);
    check("rd_one_strobe", enb_strobes - e0, 1);
  endtask

  initial begin
    RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    rsp_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_enb", ram_enb, 1'b1);
    check("rst_web", ram_web, 1'b1);
    check("rst_oeb", ram_oeb, 1'b1);
    check("rst_adr", ram_adr, 8'h00);
    check("rst_d", ram_d, 8'h00);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rdata", rsp_rdata, 8'h00);
    check("rst_init_done", init_done, 1'b0);

    // Request held pending through the quiet period must not be taken early.
    RST = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    init_wait("init");
    req_valid = 1'b0;

`ifdef SPRAM_CLEAR_EN
    do_read(8'h80, 8'h00, 0);
    do_read(8'hFF, 8'h00, 0);
`endif

    do_write(8'h10, 8'h5A);
    do_read(8'h10, 8'h5A, 0);
    check("rd_d_held", ram_d, 8'h5A);
    do_read(8'h10, 8'h5A, 5);

    do_write(8'hFF, 8'hFF);
    do_write(8'h00, 8'h01);
    do_read(8'hFF, 8'hFF, 0);
    do_read(8'h00, 8'h01, 0);

    do_write(8'h01, 8'h33);
    do_write(8'h02, 8'hCC);
    do_read(8'h02, 8'hCC, 0);
    do_read(8'h01, 8'h33, 1);

    // Reset while the controller is in CAPTURE.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    check("pre_rst_oeb", ram_oeb, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst_enb", ram_enb, 1'b1);
    check("mid_rst_oeb", ram_oeb, 1'b1);
    check("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check("mid_rst_init_done", init_done, 1'b0);
    check("mid_rst_req_ready", req_ready, 1'b0);
    RST = 1'b0;
    init_wait("reinit");

`ifdef SPRAM_CLEAR_EN
    do_read(8'h10, 8'h00, 0);
`else
    do_read(8'h10, 8'h5A, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
